// File: rtl/npc_pkg.sv
// npc_pkg: shared state, load-size encodings and datapath width
package npc_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_RSV = 2'd3} size_e;
endpackage

// File: rtl/load_align.sv
// load_align: lane select, sign/zero extension and misalignment detect for loads
module load_align
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  size_e           size,
    input  logic            uns,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        data = size == SZ_B ? {{(XLEN-8){~uns & b[7]}}, b}
             : size == SZ_H ? {{(XLEN-16){~uns & h[15]}}, h}
             : word;
        misaligned = size == SZ_H ? off[0] : size == SZ_W ? |off : size == SZ_RSV;
    end
endmodule

// File: rtl/wbu.sv
// wbu: writeback unit retiring ALU results and issuing/aligning single-word loads
module wbu
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_is_load,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit,
    output logic                  misalign
);
    state_e                state_q, state_d;
    size_e                 size_q, size_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] res_q, res_d, ld_data;
    logic                  wen_q, wen_d, uns_q, uns_d, mis_q, mis_d, ld_mis;

    // res_q holds the load address until the response replaces it with load data
    load_align u_align (
        .word(mem_rsp_data),
        .off(res_q[1:0]),
        .size(size_q),
        .uns(uns_q),
        .data(ld_data),
        .misaligned(ld_mis)
    );

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        rd_d    = rd_q;
        res_d   = res_q;
        wen_d   = wen_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = in_is_load ? REQ : WB;
                size_d  = size_e'(in_size);
                rd_d    = in_rd;
                res_d   = in_result;
                wen_d   = in_rd_wen;
                uns_d   = in_unsigned;
                mis_d   = 1'b0;
            end
            REQ:  state_d = mem_req_ready ? WAIT : REQ;
            WAIT: if (mem_rsp_valid) begin
                state_d = WB;
                res_d   = ld_data;
                mis_d   = ld_mis;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= SZ_B;
            rd_q    <= '0;
            res_q   <= '0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            wen_q   <= wen_d;
            uns_q   <= uns_d;
            mis_q   <= mis_d;
        end
    end

    assign in_ready      = state_q == IDLE;
    assign mem_req_valid = state_q == REQ;
    assign mem_req_addr  = {res_q[DATA_WIDTH-1:2], 2'b00};
    assign commit        = state_q == WB;
    assign misalign      = commit & mis_q;
    assign rf_wen        = commit & wen_q & (rd_q != '0) & ~mis_q;
    assign rf_waddr      = rd_q;
    assign rf_wdata      = res_q;
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed self-checking bench for the writeback unit
module tb_wbu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_rd_wen, in_is_load, in_unsigned;
    logic [4:0]  in_rd, rf_waddr;
    logic [31:0] in_result, mem_req_addr, mem_rsp_data, rf_wdata;
    logic [1:0]  in_size;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid, rf_wen, commit, misalign;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    wbu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_result(in_result), .in_is_load(in_is_load), .in_size(in_size), .in_unsigned(in_unsigned),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .commit(commit), .misalign(misalign)
    );

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_chk++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset mem_req_valid: got %b want 0", mem_req_valid); end
        n_chk++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset mem_req_addr: got %h want 0", mem_req_addr); end
        n_chk++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset rf_wen: got %b want 0", rf_wen); end
        n_chk++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset rf_waddr: got %h want 0", rf_waddr); end
        n_chk++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset rf_wdata: got %h want 0", rf_wdata); end
        n_chk++; if (commit !== 1'b0) begin n_fail++; $display("FAIL reset commit: got %b want 0", commit); end
        n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset misalign: got %b want 0", misalign); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        in_valid = 1'b1; in_rd = 5'd5; in_rd_wen = 1'b1; in_result = 32'h1234_5678; in_is_load = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        n_chk++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL alu rf_wen: got %b want 1", rf_wen); end
        n_chk++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu rf_waddr: got %0d want 5", rf_waddr); end
        n_chk++; if (rf_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL alu rf_wdata: got %h want 12345678", rf_wdata); end
        n_chk++; if (commit !== 1'b1) begin n_fail++; $display("FAIL alu commit: got %b want 1", commit); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL alu in_ready in WB: got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_chk++; if (commit !== 1'b0) begin n_fail++; $display("FAIL alu commit pulse width: got %b want 0", commit); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alu in_ready back: got %b want 1", in_ready); end
    endtask

    task automatic test_rd0;
        in_valid = 1'b1; in_rd = 5'd0; in_rd_wen = 1'b1; in_result = 32'hAAAA_5555; in_is_load = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        n_chk++; if (commit !== 1'b1) begin n_fail++; $display("FAIL rd0 commit: got %b want 1", commit); end
        n_chk++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rd0 rf_wen: got %b want 0", rf_wen); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [3:0] seq;
        in_valid = 1'b1; in_rd = 5'd3; in_rd_wen = 1'b1; in_result = 32'h0000_0011; in_is_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seq = {seq[2:0], commit};
        end
        in_valid = 1'b0;
        n_chk++; if (seq !== 4'b1010) begin n_fail++; $display("FAIL back_to_back commit pattern: got %b want 1010", seq); end
        @(posedge clk); #1;
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                            input logic [31:0] rsp, input int rdy_wait, input int rsp_wait,
                            output logic [31:0] req_addr, output logic held, output int commits,
                            output logic [31:0] wdata, output logic wen, output logic mis);
        held = 1'b1; commits = 0;
        in_valid = 1'b1; in_rd = 5'd10; in_rd_wen = 1'b1; in_result = addr; in_is_load = 1'b1;
        in_size = size; in_unsigned = uns; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        req_addr = mem_req_addr;
        for (int i = 0; i <= rdy_wait; i++) begin
            if (!mem_req_valid || in_ready) held = 1'b0;
            commits += int'(commit);
            mem_req_ready = (i == rdy_wait);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i <= rsp_wait; i++) begin
            if (mem_req_valid || in_ready) held = 1'b0;
            commits += int'(commit);
            mem_rsp_valid = (i == rsp_wait);
            mem_rsp_data = (i == rsp_wait) ? rsp : 32'h5A5A_5A5A;
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        wdata = rf_wdata; wen = rf_wen; mis = misalign;
        commits += int'(commit);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            commits += int'(commit);
        end
    endtask

    task automatic test_byte_load;
        logic [31:0] ra, wd;
        logic h, we, mi;
        int c;
        run_load(32'h8000_0003, 2'd0, 1'b0, 32'h80FF_FFFF, 0, 0, ra, h, c, wd, we, mi);
        n_chk++; if (ra !== 32'h8000_0000) begin n_fail++; $display("FAIL lb req_addr: got %h want 80000000", ra); end
        n_chk++; if (wd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb signed wdata: got %h want ffffff80", wd); end
        n_chk++; if (we !== 1'b1) begin n_fail++; $display("FAIL lb rf_wen: got %b want 1", we); end
        run_load(32'h8000_0003, 2'd0, 1'b1, 32'h80FF_FFFF, 0, 0, ra, h, c, wd, we, mi);
        n_chk++; if (wd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu wdata: got %h want 00000080", wd); end
        run_load(32'h0000_0000, 2'd1, 1'b1, 32'h1234_8001, 0, 0, ra, h, c, wd, we, mi);
        n_chk++; if (wd !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu low wdata: got %h want 00008001", wd); end
        run_load(32'h8000_0010, 2'd2, 1'b0, 32'hCAFE_F00D, 1, 2, ra, h, c, wd, we, mi);
        n_chk++; if (wd !== 32'hCAFE_F00D || mi !== 1'b0) begin n_fail++; $display("FAIL lw wdata/misalign: got %h/%b want cafef00d/0", wd, mi); end
    endtask

    task automatic test_half_stall;
        logic [31:0] ra, wd;
        logic h, we, mi;
        int c;
        run_load(32'h8000_0002, 2'd1, 1'b0, 32'hBEEF_1234, 3, 4, ra, h, c, wd, we, mi);
        n_chk++; if (ra !== 32'h8000_0000) begin n_fail++; $display("FAIL lh req_addr: got %h want 80000000", ra); end
        n_chk++; if (h !== 1'b1) begin n_fail++; $display("FAIL lh stall handshake held: got %b want 1", h); end
        n_chk++; if (c !== 1) begin n_fail++; $display("FAIL lh commit count: got %0d want 1", c); end
        n_chk++; if (wd !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL lh wdata: got %h want ffffbeef", wd); end
    endtask

    task automatic test_misalign;
        logic [31:0] ra, wd;
        logic h, we, mi;
        int c;
        run_load(32'h8000_0006, 2'd2, 1'b0, 32'h1111_2222, 0, 1, ra, h, c, wd, we, mi);
        n_chk++; if (ra !== 32'h8000_0004) begin n_fail++; $display("FAIL misalign req_addr: got %h want 80000004", ra); end
        n_chk++; if (mi !== 1'b1) begin n_fail++; $display("FAIL misalign flag: got %b want 1", mi); end
        n_chk++; if (we !== 1'b0) begin n_fail++; $display("FAIL misalign rf_wen: got %b want 0", we); end
        n_chk++; if (c !== 1) begin n_fail++; $display("FAIL misalign commit count: got %0d want 1", c); end
        run_load(32'h8000_0001, 2'd1, 1'b0, 32'h1111_2222, 0, 0, ra, h, c, wd, we, mi);
        n_chk++; if (mi !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL misalign half flag/wen: got %b/%b want 1/0", mi, we); end
    endtask

    task automatic test_reset_wait;
        logic bad, rdy;
        in_valid = 1'b1; in_rd = 5'd9; in_rd_wen = 1'b1; in_result = 32'h8000_0000;
        in_is_load = 1'b1; in_size = 2'd2; in_unsigned = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1 mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait async in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1 rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        bad = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 mem_rsp_valid = 1'b0;
            bad |= rf_wen | commit | mem_req_valid;
            rdy &= in_ready;
        end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rst_wait stale rsp activity: got %b want 0", bad); end
        n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rst_wait in_ready: got %b want 1", rdy); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_result = '0; in_is_load = 1'b0;
        in_size = 2'd0; in_unsigned = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        test_reset;
        test_alu;
        test_rd0;
        test_back_to_back;
        test_byte_load;
        test_half_stall;
        test_misalign;
        test_reset_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
